// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int ITER_COUNT = 32;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle on operand
// magnitudes, signs restored when the result is latched.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            we_out,
  output logic [4:0]      rd_out
);

  localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

  state_e          state_q;
  funct3_e         f3_q;
  logic [4:0]      cnt_q, rd_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q, result_q;
  logic            neg_q, div0_q, busy_q, done_q, we_q;

  logic [XLEN-1:0] hi_d, lo_d, a_mag, b_mag, res_fix;
  logic            sgn_a, sgn_b, neg_in;
  logic [XLEN:0]   shifted, add_a, add_b;
  logic [XLEN+1:0] sum;
  logic [2*XLEN-1:0] prod, prod_s;
  funct3_e         f3_in;

  // Operand signedness and magnitudes for the request being accepted.
  always_comb begin
    f3_in  = funct3_e'(funct3);
    sgn_a  = op_a[XLEN-1] && (f3_in inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    sgn_b  = op_b[XLEN-1] && (f3_in inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
    a_mag  = sgn_a ? -op_a : op_a;
    b_mag  = sgn_b ? -op_b : op_b;
    // Remainder follows the dividend; everything else follows sign(a)^sign(b).
    neg_in = (f3_in inside {F3_REM, F3_REMU}) ? sgn_a : (sgn_a ^ sgn_b);
  end

  // One iteration through the shared 33-bit adder/subtractor.
  // Multiply: {hi,lo} shifts right, lo holds the multiplier.
  // Divide: hi is the partial remainder, lo shifts the dividend out / quotient in.
  always_comb begin
    shifted = {hi_q, lo_q[XLEN-1]};
    add_a   = f3_q[2] ? shifted : {1'b0, hi_q};
    add_b   = {1'b0, b_q};
    sum     = {1'b0, add_a} + {1'b0, add_b ^ {(XLEN+1){f3_q[2]}}} + {{(XLEN+1){1'b0}}, f3_q[2]};
    if (f3_q[2]) begin
      // Carry out set means no borrow: divisor fits, take the difference.
      if (sum[XLEN+1]) begin
        hi_d = sum[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = shifted[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_d = {1'b0, hi_q[XLEN-1:1]};
      lo_d = {hi_q[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix and op select, applied to the values of the final iteration.
  always_comb begin
    prod   = {hi_d, lo_d};
    prod_s = neg_q ? -prod : prod;
    case (f3_q)
      F3_MUL:                     res_fix = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_fix = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:            res_fix = div0_q ? '1 : (neg_q ? -lo_d : lo_d);
      default:                    res_fix = neg_q ? -hi_d : hi_d;
    endcase
  end

  // Control FSM and datapath registers; outputs are all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      f3_q     <= F3_MUL;
      cnt_q    <= '0;
      rd_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          f3_q    <= f3_in;
          rd_q    <= rd_in;
          hi_q    <= '0;
          lo_q    <= a_mag;
          b_q     <= b_mag;
          neg_q   <= neg_in;
          div0_q  <= (op_b == '0);
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_CALC;
        end
        S_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            result_q <= res_fix;
            done_q   <= 1'b1;
            we_q     <= (rd_q != 5'd0);
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign we_out = we_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .we_out(we_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit / int arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, optionally re-pulse start mid-op, check latency and outputs.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int pulse_at);
    int k;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
    chk("busy_after_accept", busy, 1'b1);
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (pulse_at != 0 && k == pulse_at) start = 1'b1;
      else start = 1'b0;
      if (done) break;
    end
    start = 1'b0;
    chk($sformatf("latency f=%0d", f), k, 32);
    chk($sformatf("result f=%0d a=%h b=%h", f, a, b), result, exp);
    chk("we_out", we_out, rd != 0);
    chk("rd_out", rd_out, rd);
    chk("busy_in_done", busy, 1'b1);
    @(posedge clk); #1;
    chk("done_pulse_end", done, 1'b0);
    chk("busy_end", busy, 1'b0);
    chk("result_hold", result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    logic [2:0] f;
    logic [31:0] a, b;
    logic [4:0] rd;

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_we", we_out, 1'b0);
    chk("rst_rd", rd_out, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed corner cases, first one on the first edge after reset release.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100, 32'd0, 5'd6, 32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'd100, 32'd0, 5'd7, 32'd100, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 0);
    run_op(3'd4, 32'hFFFF_FF9C, 32'd0, 5'd10, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'hFFFF_FF9C, 32'd0, 5'd11, 32'hFFFF_FF9C, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, 0);

    // Mid-op start is ignored; rd=0 suppresses the write enable.
    run_op(3'd0, 32'd12345, 32'd678, 5'd0, 32'd8369910, 9);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("no_second_done", dn, 0);

    // Reset in the middle of CALC aborts the op.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 32'd0);
    chk("abort_we", we_out, 1'b0);
    chk("abort_rd", rd_out, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || we_out) dn++;
    end
    chk("no_done_after_abort", dn, 0);
    run_op(3'd4, 32'd1000, 32'd7, 5'd13, 32'd142, 0);

    // Random ops against the reference model.
    repeat (60) begin
      f  = 3'($urandom);
      a  = pick();
      b  = pick();
      rd = 5'($urandom);
      run_op(f, a, b, rd, ref_op(f, a, b), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
